seed_reader: RTL and testbench
==============================

SEED_READER -- requirements
Module: seed_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of the seed memory port.
REQ-002 SHALL have parameter DATA_W, default 32, seed word width.
REQ-003 SHALL have parameter DEPTH, default 2500, number of valid words in the seed memory.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a read burst; sampled only in IDLE.
REQ-007 SHALL have port base_addr  input  ADDR_W  first word address, sampled with start.
REQ-008 SHALL have port word_count  input  ADDR_W  number of words to read, sampled with start.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a burst completes.
REQ-011 SHALL have port address  output  ADDR_W  Avalon-MM master word address to the memory slave port.
REQ-012 SHALL have port chipselect  output  1  read strobe; the slave's address register captures address when this is high.
REQ-013 SHALL have port write  output  1  constant 0.
REQ-014 SHALL have port byteenable  output  4  constant 4'hF.
REQ-015 SHALL have port clken  output  1  constant 1.
REQ-016 SHALL have port readdata  input  DATA_W  slave read data, valid exactly 1 cycle after a chipselect cycle.
REQ-017 SHALL have port seed_data  output  DATA_W  stream data to the consumer.
REQ-018 SHALL have port seed_valid  output  1  stream valid.
REQ-019 SHALL have port seed_ready  input  1  stream ready; a transfer occurs on a cycle where valid and ready are both high.

Function
REQ-020 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-021 IDLE->READ SHALL occur on start=1 with word_count!=0; IDLE->DONE SHALL occur on start=1 with word_count=0, with no reads issued.
REQ-022 In READ, chipselect SHALL assert only when the 2-entry output FIFO occupancy plus in-flight reads is less than 2.
REQ-023 Each issued read SHALL increment address; address DEPTH-1 SHALL wrap to 0.
REQ-024 readdata SHALL be pushed into the FIFO on the cycle after each chipselect cycle. The push SHALL be unconditional, and overflow SHALL be impossible by REQ-022.
REQ-025 READ->DRAIN SHALL occur when the remaining-read counter reaches 0. DRAIN->DONE SHALL occur when the FIFO is empty and no read is in flight.
REQ-026 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-027 Stream output SHALL follow the valid/ready rule: seed_data SHALL be held stable while seed_valid=1 and seed_ready=0. A simultaneous push and pop SHALL keep occupancy unchanged.
REQ-028 Words SHALL be delivered in address order, without loss or duplication.
REQ-029 With seed_ready held at 1, throughput SHALL be 1 word/cycle. First seed_valid SHALL occur 2 cycles after start.
REQ-030 start SHALL be ignored while busy=1.

Reset
REQ-031 While reset_n=0 at a clk edge: state=IDLE, FIFO empty, in-flight cleared, address=0, chipselect=0, seed_valid=0, seed_data=0, busy=0, done=0.
REQ-032 Reset mid-burst SHALL abandon the burst. Any readdata returning on the following cycle SHALL be discarded. No done pulse SHALL be generated.

Configuration
REQ-033 Macro SEED_READER_WRAP_EN, when defined: on reaching 0 remaining reads, the block SHALL reload word_count and base_addr values captured at start and continue in READ indefinitely. done SHALL never pulse. Only reset SHALL stop the block.
REQ-034 Without SEED_READER_WRAP_EN: the block SHALL behave as REQ-020..REQ-030, performing a single burst per start.

Verification
REQ-035 base_addr=0, word_count=4, mem[i]=i+100, seed_ready=1 -> seed_data 100,101,102,103 on consecutive cycles, first at start+2; done one cycle after the last transfer.
REQ-036 base_addr=2498, word_count=4 -> addresses 2498,2499,0,1 read; data delivered in that order.
REQ-037 word_count=8, seed_ready toggling 1,0,0,1,... -> all 8 words delivered exactly once in order; data stable during stalls; chipselect never issued with occupancy plus in-flight equal to 2.
REQ-038 word_count=0 -> no chipselect; done at start+1; busy high for exactly 1 cycle.
REQ-039 reset_n=0 for 1 cycle after the 3rd chipselect of a 10-word burst -> all outputs at reset values next cycle; no further seed_valid; no done.
REQ-040 SEED_READER_WRAP_EN defined, base_addr=5, word_count=3 -> repeating data mem[5],mem[6],mem[7],mem[5],... for at least 12 words; done stays 0.

Source files
------------

// File: rtl/seed_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : seed_reader_if
// Purpose  : Control, Avalon-MM memory and stream signals of seed_reader.
// Revision : 1.0 - initial release
// ============================================================================
interface seed_reader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);

  // Burst control
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic              busy;
  logic              done;

  // Avalon-MM master towards the seed memory
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write;
  logic [3:0]        byteenable;
  logic              clken;
  logic [DATA_W-1:0] readdata;

  // Stream towards the consumer
  logic [DATA_W-1:0] seed_data;
  logic              seed_valid;
  logic              seed_ready;

  modport master (
    input  start, base_addr, word_count, readdata, seed_ready,
    output busy, done, address, chipselect, write, byteenable, clken,
           seed_data, seed_valid
  );

  modport slave (
    output start, base_addr, word_count, readdata, seed_ready,
    input  busy, done, address, chipselect, write, byteenable, clken,
           seed_data, seed_valid
  );

endinterface

`default_nettype wire

// File: rtl/seed_reader.sv
`default_nettype none
// ============================================================================
// Module   : seed_reader
// Purpose  : Reads a burst of seed words over Avalon-MM (read latency 1) and
//            streams them out through a 2-entry FIFO with valid/ready.
//            Macro SEED_READER_WRAP_EN: reload the burst forever, never done.
// Revision : 1.0 - initial release
// ============================================================================
module seed_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2500
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  seed_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] c_ONE       = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remain;
  logic              r_inflight;
`ifdef SEED_READER_WRAP_EN
  logic [ADDR_W-1:0] r_base_cap;
  logic [ADDR_W-1:0] r_count_cap;
`endif

  logic [DATA_W-1:0] r_fifo [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_occ;

  logic [1:0]        w_slots_used;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_accept_start;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [DATA_W-1:0] w_data;
  logic [1:0]        w_occ_nxt;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_busy;
  logic              w_done;

  // Occupancy never exceeds 2 with a read in flight, so 2 bits suffice.
  assign w_slots_used   = r_occ + {1'b0, r_inflight};
  assign w_issue        = (r_state == S_READ) && (r_remain != '0) &&
                          (w_slots_used < 2'd2);
  assign w_last_issue   = w_issue && (r_remain == c_ONE);
  assign w_accept_start = (r_state == S_IDLE) && bus.start;
  assign w_addr_inc     = (r_addr == c_LAST_ADDR) ? '0 : r_addr + c_ONE;

  // The word returning this cycle bypasses an empty FIFO so the first word
  // is visible two cycles after start; it is still pushed unconditionally.
  assign w_push  = r_inflight;
  assign w_valid = (r_occ != 2'd0) || r_inflight;
  assign w_data  = (r_occ != 2'd0) ? r_fifo[r_rd_ptr] :
                   (r_inflight     ? bus.readdata     : '0);
  assign w_pop   = w_valid && bus.seed_ready;

  always_comb begin
    w_occ_nxt = r_occ;
    unique case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + 2'd1;
      2'b01:   w_occ_nxt = r_occ - 2'd1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_state_nxt = (bus.word_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
`ifdef SEED_READER_WRAP_EN
        w_state_nxt = S_READ;
`else
        if (w_last_issue) begin
          w_state_nxt = S_DRAIN;
        end
`endif
      end
      S_DRAIN: begin
        // Leave once the last word is consumed, so done trails it by a cycle.
        if (w_occ_nxt == 2'd0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Address / remaining-read bookkeeping and FIFO storage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_remain    <= '0;
      r_inflight  <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_occ       <= 2'd0;
      r_fifo[0]   <= '0;
      r_fifo[1]   <= '0;
`ifdef SEED_READER_WRAP_EN
      r_base_cap  <= '0;
      r_count_cap <= '0;
`endif
    end else begin
      r_inflight <= w_issue;
      r_occ      <= w_occ_nxt;

      if (w_push) begin
        r_fifo[r_wr_ptr] <= bus.readdata;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end

      if (w_accept_start) begin
        r_addr      <= bus.base_addr;
        r_remain    <= bus.word_count;
`ifdef SEED_READER_WRAP_EN
        r_base_cap  <= bus.base_addr;
        r_count_cap <= bus.word_count;
`endif
      end else if (w_issue) begin
`ifdef SEED_READER_WRAP_EN
        if (w_last_issue) begin
          r_addr   <= r_base_cap;
          r_remain <= r_count_cap;
        end else begin
          r_addr   <= w_addr_inc;
          r_remain <= r_remain - c_ONE;
        end
`else
        r_addr   <= w_addr_inc;
        r_remain <= r_remain - c_ONE;
`endif
      end
    end
  end

  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.address    = r_addr;
  assign bus.chipselect = w_issue;
  assign bus.write      = 1'b0;
  assign bus.byteenable = 4'hF;
  assign bus.clken      = 1'b1;
  assign bus.seed_data  = w_data;
  assign bus.seed_valid = w_valid;

endmodule

`default_nettype wire

// File: tb/tb_seed_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_seed_reader
// Purpose  : Randomized self-checking bench for seed_reader against a queue
//            model of the expected word sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seed_reader;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2500;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seed_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  seed_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [DATA_W-1:0] mem_word(input int a);
    return DATA_W'(a + 100);
  endfunction

  // Memory slave: data one cycle after chipselect, garbage otherwise.
  always @(posedge clk) begin
    if (bus.chipselect) bus.readdata <= mem_word(int'(bus.address));
    else                bus.readdata <= $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_reset_values();
    chk("rst_busy",       bus.busy,       0);
    chk("rst_done",       bus.done,       0);
    chk("rst_cs",         bus.chipselect, 0);
    chk("rst_valid",      bus.seed_valid, 0);
    chk("rst_data",       bus.seed_data,  0);
    chk("rst_address",    bus.address,    0);
    chk("rst_write",      bus.write,      0);
    chk("rst_byteenable", bus.byteenable, 4'hF);
    chk("rst_clken",      bus.clken,      1);
  endtask

  // mode: 0 ready=1, 1 ready 1,0,0,..., 2 random. rst3: reset after 3rd read.
  task automatic run_burst(input int base, input int cnt, input int mode, input bit rst3);
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] held = '0;
    int  issued = 0, delivered = 0, last_xfer = -1, first_valid = -1;
    int  rst_at = -1;
    bit  stalled = 1'b0, finished = 1'b0;
    int  budget = 4 * cnt + 20;
    for (int k = 0; k < cnt; k++) exp_q.push_back(mem_word((base + k) % DEPTH));

    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.base_addr  = ADDR_W'(base);
    bus.word_count = ADDR_W'(cnt);
    bus.seed_ready = ready_for(mode, 0);
    #4;
    chk("idle_before_start", bus.busy, 0);

    for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
      @(posedge clk); #1;
      if (rst_at >= 0) begin
        bus.start = 1'b0;
        reset_n   = 1'b0;
      end else begin
        bus.start      = 1'($urandom_range(0, 1));
        bus.base_addr  = ADDR_W'($urandom);
        bus.word_count = ADDR_W'($urandom);
      end
      bus.seed_ready = ready_for(mode, cyc);
      #4;
      chk("busy", bus.busy, 1);
      if (bus.chipselect) begin
        chk("cs_within_burst", issued < cnt, 1);
        chk("cs_address", bus.address, (base + issued) % DEPTH);
        chk("cs_credit", (issued - delivered) < 2, 1);
        issued++;
      end
      if (stalled) begin
        chk("stall_valid", bus.seed_valid, 1);
        chk("stall_data", bus.seed_data, held);
      end
      if (mode == 0 && cyc >= 2 && cyc <= cnt + 1) chk("stream_gap", bus.seed_valid, 1);
      if (bus.seed_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (bus.seed_ready) begin
          if (exp_q.size() == 0) chk("extra_word", delivered + 1, cnt);
          else                   chk("word_data", bus.seed_data, exp_q.pop_front());
          delivered++;
          last_xfer = cyc;
        end
      end
      stalled = bus.seed_valid && !bus.seed_ready;
      held    = bus.seed_data;
      if (rst_at >= 0) finished = 1'b1;
      else if (rst3 && issued == 3) rst_at = cyc;
      if (bus.done) begin
        finished = 1'b1;
        chk("done_in_reset_test", rst3, 0);
        if (cnt == 0) begin
          chk("zero_done_time", cyc, 1);
          chk("zero_no_reads", issued, 0);
        end else begin
          chk("done_latency", cyc, last_xfer + 1);
          chk("delivered", delivered, cnt);
          chk("reads_issued", issued, cnt);
        end
        if (mode == 0 && cnt > 0) chk("first_valid_time", first_valid, 2);
      end
    end
    chk("burst_finished", finished, 1);

    @(posedge clk); #1;
    reset_n   = 1'b1;
    bus.start = 1'b0;
    #4;
    if (rst3) begin
      check_reset_values();
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        bus.seed_ready = 1'($urandom_range(0, 1));
        #4;
        chk("post_rst_valid", bus.seed_valid, 0);
        chk("post_rst_done", bus.done, 0);
        chk("post_rst_cs", bus.chipselect, 0);
      end
    end else begin
      chk("busy_after_done", bus.busy, 0);
      chk("done_one_cycle", bus.done, 0);
    end
  endtask

  task automatic run_wrap(input int base, input int cnt);
    int k = 0, issued = 0;
    bit stalled = 1'b0;
    logic [DATA_W-1:0] held = '0;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.base_addr  = ADDR_W'(base);
    bus.word_count = ADDR_W'(cnt);
    bus.seed_ready = 1'b1;
    for (int cyc = 1; cyc <= 120 && k < 15; cyc++) begin
      @(posedge clk); #1;
      bus.start      = 1'($urandom_range(0, 1));
      bus.seed_ready = 1'($urandom_range(0, 1));
      #4;
      chk("wrap_done_low", bus.done, 0);
      if (bus.chipselect) begin
        chk("wrap_cs_address", bus.address, base + (issued % cnt));
        issued++;
      end
      if (stalled) chk("wrap_stall_data", bus.seed_data, held);
      if (bus.seed_valid && bus.seed_ready) begin
        chk("wrap_data", bus.seed_data, mem_word(base + (k % cnt)));
        k++;
      end
      stalled = bus.seed_valid && !bus.seed_ready;
      held    = bus.seed_data;
    end
    chk("wrap_word_total", k >= 15, 1);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    bus.seed_ready = 1'b0;
    reset_n        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #4;
    check_reset_values();

`ifdef SEED_READER_WRAP_EN
    run_wrap(5, 3);
`else
    run_burst(0, 4, 0, 1'b0);
    run_burst(2498, 4, 0, 1'b0);
    run_burst(int'($urandom_range(0, DEPTH - 1)), 8, 1, 1'b0);
    run_burst(int'($urandom_range(0, DEPTH - 1)), 0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 12)), 2, 1'b0);
    end
    run_burst(int'($urandom_range(0, DEPTH - 1)), 10, 2, 1'b1);
    run_burst(DEPTH - 3, 6, 2, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
